// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO and a busy handshake.
// Latency: MULT_CYCLES or DIV_CYCLES edges from start to commit; starts while busy are dropped.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [3:0]  MDOP,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic          pwr_q, pwr_d;
    logic          done_q, done_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, sdiv, udiv, sq, sr, s_hi, s_lo, uq, ur;

    assign prod_s = $signed({{32{in1[31]}}, in1}) * $signed({{32{in2[31]}}, in2});
    assign prod_u = {32'd0, in1} * {32'd0, in2};

    // Signed divide runs on magnitudes so the -2^31 / -1 case wraps cleanly.
    assign abs_a = in1[31] ? (32'd0 - in1) : in1;
    assign abs_b = in2[31] ? (32'd0 - in2) : in2;
    assign sdiv  = (in2 == 32'd0) ? 32'd1 : abs_b;
    assign udiv  = (in2 == 32'd0) ? 32'd1 : in2;
    assign sq    = abs_a / sdiv;
    assign sr    = abs_a % sdiv;
    assign s_lo  = (in1[31] ^ in2[31]) ? (32'd0 - sq) : sq;
    assign s_hi  = in1[31] ? (32'd0 - sr) : sr;
    assign uq    = in1 / udiv;
    assign ur    = in1 % udiv;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDOP)
                        4'd0, 4'd1: begin
                            phi_d   = (MDOP == 4'd0) ? prod_s[63:32] : prod_u[63:32];
                            plo_d   = (MDOP == 4'd0) ? prod_s[31:0]  : prod_u[31:0];
                            pwr_d   = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        4'd2, 4'd3: begin
                            phi_d   = (MDOP == 4'd2) ? s_hi : ur;
                            plo_d   = (MDOP == 4'd2) ? s_lo : uq;
                            pwr_d   = (in2 != 32'd0);
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        4'd4:    hi_d = in1;
                        4'd5:    lo_d = in1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    // Divide-by-zero still pulses done but leaves HI/LO untouched.
                    if (pwr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized ops against an arithmetic model.
module tb_mdu;
    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in1, in2;
    logic [3:0]  MDOP;
    logic        start;
    logic        busy, done;
    logic [31:0] HI, LO;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .MDOP(MDOP),
        .start(start), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Architectural model: what HI/LO hold once an op has fully completed.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            4'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            4'd1: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            4'd2: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            4'd3: if (b != 0) begin q = ua / ub; r = ua % ub; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            4'd4: exp_hi = a;
            4'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Present one start for a single edge, then scramble operands.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; MDOP = op; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0; in1 = $urandom; in2 = $urandom; MDOP = 4'($urandom);
    endtask

    // Count edges until done is seen (bounded); busy_ok drops if busy fell early.
    task automatic wait_done(output int k, output bit busy_ok);
        k = 0; busy_ok = 1'b1;
        while (k < 50) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; MDOP = '0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (HI !== 32'h0) $display("FAIL reset_hi: got %h want 0", HI); else pass_cnt++;
        total_cnt++; if (LO !== 32'h0) $display("FAIL reset_lo: got %h want 0", LO); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(4'd4, 32'h12345678, 32'h0); model(4'd4, 32'h12345678, 32'h0);
        total_cnt++; if (HI !== 32'h12345678) $display("FAIL mthi_hi: got %h want 12345678", HI); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_mult;
        int k; bit bok;
        issue(4'd0, 32'hFFFFFFFD, 32'd5); model(4'd0, 32'hFFFFFFFD, 32'd5);
        wait_done(k, bok);
        total_cnt++; if (k != NM || !bok) $display("FAIL mult_latency: got %0d busy_ok=%0d want %0d", k, bok, NM); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mult_busy_fall: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF1)
            $display("FAIL mult_res: got %h_%h want ffffffff_fffffff1", HI, LO); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b want 0", done); else pass_cnt++;
        issue(4'd1, 32'hFFFFFFFD, 32'd5); model(4'd1, 32'hFFFFFFFD, 32'd5);
        wait_done(k, bok);
        total_cnt++; if (HI !== 32'h4 || LO !== 32'hFFFFFFF1 || k != NM)
            $display("FAIL multu_res: got %h_%h k=%0d want 00000004_fffffff1 k=%0d", HI, LO, k, NM); else pass_cnt++;
    endtask

    task automatic test_div;
        int k; bit bok;
        issue(4'd2, 32'hFFFFFFF9, 32'd2); model(4'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(k, bok);
        total_cnt++; if (k != ND || !bok) $display("FAIL div_latency: got %0d busy_ok=%0d want %0d", k, bok, ND); else pass_cnt++;
        total_cnt++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD)
            $display("FAIL div_res: got %h_%h want ffffffff_fffffffd", HI, LO); else pass_cnt++;
        issue(4'd3, 32'd7, 32'd2); model(4'd3, 32'd7, 32'd2);
        wait_done(k, bok);
        total_cnt++; if (HI !== 32'd1 || LO !== 32'd3) $display("FAIL divu_res: got %h_%h want 1_3", HI, LO); else pass_cnt++;
        issue(4'd2, 32'h80000000, 32'hFFFFFFFF); model(4'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(k, bok);
        total_cnt++; if (HI !== 32'h0 || LO !== 32'h80000000)
            $display("FAIL div_ovf: got %h_%h want 00000000_80000000", HI, LO); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        int k; bit bok;
        issue(4'd4, 32'hAAAA0000, 32'h0); model(4'd4, 32'hAAAA0000, 32'h0);
        issue(4'd5, 32'h0000BBBB, 32'h0); model(4'd5, 32'h0000BBBB, 32'h0);
        issue(4'd2, 32'd1234, 32'd0);
        wait_done(k, bok);
        total_cnt++; if (k != ND || !bok) $display("FAIL divz_latency: got %0d busy_ok=%0d want %0d", k, bok, ND); else pass_cnt++;
        total_cnt++; if (HI !== 32'hAAAA0000 || LO !== 32'h0000BBBB)
            $display("FAIL divz_keep: got %h_%h want aaaa0000_0000bbbb", HI, LO); else pass_cnt++;
    endtask

    task automatic test_busy_starts;
        int k;
        issue(4'd0, 32'd3, 32'd5); model(4'd0, 32'd3, 32'd5);
        for (k = 1; k < 50; k++) begin
            start = 1'b0; in1 = $urandom; in2 = $urandom;
            if (k == 2) begin start = 1'b1; MDOP = 4'd5; in1 = 32'hDEAD; end
            if (k == 4) begin start = 1'b1; MDOP = 4'd3; in1 = 32'd100; in2 = 32'd7; end
            @(posedge clk); #1;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        total_cnt++; if (k != NM) $display("FAIL busy_start_latency: got %0d want %0d", k, NM); else pass_cnt++;
        total_cnt++; if (HI !== 32'h0 || LO !== 32'd15) $display("FAIL busy_start_res: got %h_%h want 0_f", HI, LO); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL busy_start_drop: got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int k; bit bok;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        issue(4'd1, a, b); model(4'd1, a, b);
        for (k = 1; k < 50; k++) begin
            start = (k == NM); MDOP = 4'd4; in1 = 32'h55555555;
            @(posedge clk); #1;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        total_cnt++; if (HI !== exp_hi || LO !== exp_lo || k != NM)
            $display("FAIL b2b_first: got %h_%h k=%0d want %h_%h k=%0d", HI, LO, k, exp_hi, exp_lo, NM); else pass_cnt++;
        a = $urandom; b = $urandom_range(1, 1000);
        issue(4'd3, a, b); model(4'd3, a, b);
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", busy); else pass_cnt++;
        wait_done(k, bok);
        total_cnt++; if (HI !== exp_hi || LO !== exp_lo || k != ND)
            $display("FAIL b2b_second: got %h_%h k=%0d want %h_%h k=%0d", HI, LO, k, exp_hi, exp_lo, ND); else pass_cnt++;
    endtask

    task automatic test_random;
        int k; bit bok;
        logic [3:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 5));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 9)) ^ {32{b[31]}};
                default: ;
            endcase
            issue(op, a, b); model(op, a, b);
            if (op < 4'd4) begin
                wait_done(k, bok);
                total_cnt++;
                if (k != ((op < 4'd2) ? NM : ND) || !bok)
                    $display("FAIL rand_latency[%0d]: op=%0d got %0d busy_ok=%0d", i, op, k, bok);
                else pass_cnt++;
            end else begin
                total_cnt++; if (busy !== 1'b0) $display("FAIL rand_mt_busy[%0d]: got %b want 0", i, busy); else pass_cnt++;
            end
            total_cnt++;
            if (HI !== exp_hi || LO !== exp_lo)
                $display("FAIL rand_res[%0d]: op=%0d a=%h b=%h got %h_%h want %h_%h", i, op, a, b, HI, LO, exp_hi, exp_lo);
            else pass_cnt++;
        end
    endtask

    task automatic test_reserved;
        for (int i = 0; i < 4; i++) begin
            issue(4'($urandom_range(6, 15)), $urandom, $urandom);
            total_cnt++;
            if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo)
                $display("FAIL reserved[%0d]: got busy=%b %h_%h want 0 %h_%h", i, busy, HI, LO, exp_hi, exp_lo);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        bit bad_done, bad_hilo;
        issue(4'd4, 32'h0BADF00D, 32'h0);
        issue(4'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (HI !== 32'h0 || LO !== 32'h0) $display("FAIL rstmid_hilo: got %h_%h want 0_0", HI, LO); else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b1;
        bad_done = 1'b0; bad_hilo = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done !== 1'b0) bad_done = 1'b1;
            if (HI !== 32'h0 || LO !== 32'h0) bad_hilo = 1'b1;
        end
        total_cnt++; if (bad_done) $display("FAIL rstmid_no_done: got done pulse want none"); else pass_cnt++;
        total_cnt++; if (bad_hilo) $display("FAIL rstmid_hold: got %h_%h want 0_0", HI, LO); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_busy_starts;
        test_back_to_back;
        test_random;
        test_reserved;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit sitting beside the ALU in the execute stage, fed by the same two register-file operands the ALU receives. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with architectural HI/LO registers and a busy handshake; the stall controller holds issue of any HI/LO-touching instruction while `busy` is high. Results commit to HI/LO a fixed number of cycles after start.

## Interface
- `MULT_CYCLES`, 5: cycles `busy` stays high for MULT/MULTU (>=1).
- `DIV_CYCLES`, 10: cycles `busy` stays high for DIV/DIVU (>=1).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in1`  in  32  operand A (rs value; dividend for DIV/DIVU; source for MTHI/MTLO).
- `in2`  in  32  operand B (rt value; divisor).
- `MDOP`  in  4  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-15 reserved.
- `start`  in  1  qualifies `MDOP`/operands this cycle.
- `busy`  out  1  operation in flight; new starts ignored.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show a committed mult/div result.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- Reset (reset=0, any time, asynchronous): HI=0, LO=0, busy=0, done=0, cycle counter=0, pending result cleared. Reset mid-operation aborts it; HI/LO never receive the aborted result.
- States: IDLE (busy=0) and RUN (busy=1, counter>0).
- IDLE, start=1, MDOP in 0-3: latch full result into internal pending HI/LO, load counter with MULT_CYCLES or DIV_CYCLES, go RUN.
- IDLE, start=1, MDOP=4: HI<=in1 at that edge; MDOP=5: LO<=in1. No busy, no done.
- IDLE, start=1, MDOP reserved: no state change.
- RUN: counter decrements each edge; on the edge where counter is 1, HI/LO<=pending, counter<=0, busy<=0, done<=1 for exactly one cycle, back to IDLE.
- RUN, start=1 (any MDOP, incl. MTHI/MTLO): ignored entirely; operands not resampled.
- Operands only sampled at the start edge; later changes to in1/in2 have no effect.
- Arithmetic:
  - MULT: 64-bit signed product of in1, in2; HI=[63:32], LO=[31:0].
  - MULTU: 64-bit unsigned product.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient in LO, remainder in HI.
  - Divisor 0 (DIV/DIVU): full DIV_CYCLES busy period and done pulse, but HI/LO left unchanged.

## Timing
- Start accepted at edge T (busy=0): busy=1 from T through T+N; at edge T+N busy falls, HI/LO update, done rises; done falls at edge T+N+1. N = MULT_CYCLES or DIV_CYCLES.
- busy, done, HI, LO are all registered outputs; no combinational path from inputs to outputs.
- Back-to-back: a start presented in the cycle after done rises (busy=0) is accepted; minimum spacing between starts is N+1 edges... i.e. start at T+N is ignored (busy still 1 before the edge), start at T+N+... first accepted edge is T+N+1.
- MTHI/MTLO: HI/LO visible the cycle after the start edge.

## Test plan
- Reset then idle: reset low for 2 cycles -> HI=0, LO=0, busy=0, done=0; MDOP=4, start, in1=0x12345678 -> HI=0x12345678 next cycle, busy stays 0.
- MULT in1=0xFFFFFFFD (-3), in2=5 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, done one-cycle pulse; MULTU same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIV in1=0xFFFFFFF9 (-7), in2=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU in1=7, in2=2 -> LO=3, HI=1.
- Divide by zero: HI=0xAAAA0000, LO=0x0000BBBB preset via MTHI/MTLO, DIV in2=0 -> busy 10 cycles, done pulses, HI/LO unchanged.
- Start during busy: MULT 3x5 then MTLO in1=0xDEAD at cycle 2 and DIVU at cycle 4 -> both ignored; final HI=0, LO=15; operands changed mid-run have no effect.
- Reset mid-operation: DIV 100/7 started, reset low at cycle 4 -> busy=0, HI=LO=0 immediately; after release no done pulse and HI/LO stay 0.
